mem_sched: RTL

- Request scheduler between the pipeline's IF and EXE memory stages and the shared RAM2 controller.
- Arbitrates the two requesters, with EXE priority and a bounded IF starvation limit.
- Drives the controller's level request lines and tracks its done-flag handshake.
- Returns read data with single-cycle ready pulses and generates per-stage stall signals.
- Watchdog timeout latches a sticky error.

---
 rtl/mem_sched_pkg.sv | 27 ++
 rtl/mem_sched_arb.sv | 49 ++++
 rtl/mem_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_sched_pkg.sv
// Shared widths, defaults and state encoding for the RAM2 request scheduler.
package mem_sched_pkg;

  localparam int MEM_ADDR_W     = 18;
  localparam int MEM_VALUE_W    = 16;
  localparam int TIMEOUT_DEF    = 255;
  localparam int STARVE_MAX_DEF = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXE_ACK  = 3'd1,
    EXE_DONE = 3'd2,
    IF_ACK   = 3'd3,
    IF_DONE  = 3'd4,
    ERROR    = 3'd5
  } state_e;

  function automatic logic is_wait_state(input state_e st);
    logic res;
    case (st)
      EXE_ACK, EXE_DONE, IF_ACK, IF_DONE: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_sched_arb.sv
// IF/EXE arbiter: EXE wins unless IF has already lost STARVE_MAX times in a row.
module mem_sched_arb
  import mem_sched_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic exe_req,
  output logic grant_if,
  output logic grant_exe
);

  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_r;

  // Grant decision, only meaningful while the scheduler is free to arbitrate.
  always_comb begin
    grant_if  = 1'b0;
    grant_exe = 1'b0;
    if (arb_en) begin
      if (exe_req && (!if_req || (starve_r < STARVE_LIM))) begin
        grant_exe = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end else begin
        grant_if = 1'b0;
      end
    end else begin
      grant_exe = 1'b0;
    end
  end

  // Count EXE wins over a waiting IF, saturating; any IF win clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_r <= SW'(0);
    end else if (grant_if) begin
      starve_r <= SW'(0);
    end else if (grant_exe && if_req && (starve_r < STARVE_LIM)) begin
      starve_r <= starve_r + SW'(1);
    end
  end

endmodule

// File: rtl/mem_sched.sv
// Scheduler between the IF/EXE memory stages and the RAM2 controller:
// arbitration, done-flag handshake, ready pulses, stalls and a watchdog.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_VALUE_W,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              exe_req,
  input  logic              exe_rd,
  input  logic              exe_wr,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_wdata,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              exe_ready,
  output logic [DATA_W-1:0] exe_rdata,
  output logic              stall_if,
  output logic              stall_exe,
  output logic              be_need_if,
  output logic              be_need_exe,
  output logic              be_rd,
  output logic              be_wr,
  output logic [ADDR_W-1:0] be_addr_if,
  output logic [ADDR_W-1:0] be_addr_exe,
  output logic [DATA_W-1:0] be_wdata,
  input  logic              be_if_done,
  input  logic              be_exe_done,
  input  logic [DATA_W-1:0] be_if_data,
  input  logic [DATA_W-1:0] be_exe_data,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e state_r, next_s;
  logic [TW-1:0] tmo_r;
  logic tmo_hit_s, arb_en_s, grant_if_s, grant_exe_s;
  logic latch_if_s, latch_exe_s, if_fin_s, exe_fin_s;
  logic need_if_d_s, need_exe_d_s, err_d_s;
  logic if_ready_r, exe_ready_r, be_need_if_r, be_need_exe_r, be_rd_r, be_wr_r, err_r;
  logic [DATA_W-1:0] if_rdata_r, exe_rdata_r, be_wdata_r;
  logic [ADDR_W-1:0] be_addr_if_r, be_addr_exe_r;

  // The ready cycle doubles as the mandatory idle gap before the next grant.
  assign arb_en_s  = (state_r == IDLE) && !if_ready_r && !exe_ready_r;
  assign tmo_hit_s = (tmo_r == TMO_LAST);

  mem_sched_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en_s),
    .if_req    (if_req),
    .exe_req   (exe_req),
    .grant_if  (grant_if_s),
    .grant_exe (grant_exe_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= next_s;
  end

  // Next-state logic; handshake progress takes precedence over the watchdog.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_exe_s)     next_s = (exe_rd == exe_wr) ? ERROR : EXE_ACK;
        else if (grant_if_s) next_s = IF_ACK;
        else                 next_s = IDLE;
      end
      EXE_ACK: begin
        if (!be_exe_done)   next_s = EXE_DONE;
        else if (tmo_hit_s) next_s = ERROR;
        else                next_s = EXE_ACK;
      end
      EXE_DONE: begin
        if (be_exe_done)    next_s = IDLE;
        else if (tmo_hit_s) next_s = ERROR;
        else                next_s = EXE_DONE;
      end
      IF_ACK: begin
        if (!be_if_done)    next_s = IF_DONE;
        else if (tmo_hit_s) next_s = ERROR;
        else                next_s = IF_ACK;
      end
      IF_DONE: begin
        if (be_if_done)     next_s = IDLE;
        else if (tmo_hit_s) next_s = ERROR;
        else                next_s = IF_DONE;
      end
      ERROR:   next_s = ERROR;
      default: next_s = ERROR;
    endcase
  end

  // Output decode: next values of the registered controls and datapath strobes.
  always_comb begin
    need_if_d_s  = (next_s == IF_ACK);
    need_exe_d_s = (next_s == EXE_ACK);
    err_d_s      = (next_s == ERROR);
    latch_if_s   = (state_r == IDLE) && (next_s == IF_ACK);
    latch_exe_s  = (state_r == IDLE) && (next_s == EXE_ACK);
    if_fin_s     = (state_r == IF_DONE) && (next_s == IDLE);
    exe_fin_s    = (state_r == EXE_DONE) && (next_s == IDLE);
  end

  // Watchdog: restarts on every state change, counts only while waiting on the backend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_r <= TW'(0);
    end else if (next_s != state_r) begin
      tmo_r <= TW'(0);
    end else if (is_wait_state(state_r)) begin
      tmo_r <= tmo_r + TW'(1);
    end
  end

  // Registered outputs and latched backend request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      be_need_if_r  <= 1'b0;
      be_need_exe_r <= 1'b0;
      if_ready_r    <= 1'b0;
      exe_ready_r   <= 1'b0;
      err_r         <= 1'b0;
      be_rd_r       <= 1'b0;
      be_wr_r       <= 1'b0;
      be_addr_if_r  <= {ADDR_W{1'b0}};
      be_addr_exe_r <= {ADDR_W{1'b0}};
      be_wdata_r    <= {DATA_W{1'b0}};
      if_rdata_r    <= {DATA_W{1'b0}};
      exe_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      be_need_if_r  <= need_if_d_s;
      be_need_exe_r <= need_exe_d_s;
      if_ready_r    <= if_fin_s;
      exe_ready_r   <= exe_fin_s;
      err_r         <= err_d_s;
      if (latch_exe_s) begin
        be_addr_exe_r <= exe_addr;
        be_wdata_r    <= exe_wdata;
        be_rd_r       <= exe_rd;
        be_wr_r       <= exe_wr;
      end
      if (latch_if_s) be_addr_if_r <= if_addr;
      if (if_fin_s) if_rdata_r <= be_if_data;
      if (exe_fin_s && be_rd_r) exe_rdata_r <= be_exe_data;
    end
  end

  assign if_ready    = if_ready_r;
  assign exe_ready   = exe_ready_r;
  assign if_rdata    = if_rdata_r;
  assign exe_rdata   = exe_rdata_r;
  assign be_need_if  = be_need_if_r;
  assign be_need_exe = be_need_exe_r;
  assign be_rd       = be_rd_r;
  assign be_wr       = be_wr_r;
  assign be_addr_if  = be_addr_if_r;
  assign be_addr_exe = be_addr_exe_r;
  assign be_wdata    = be_wdata_r;
  assign err         = err_r;
  assign stall_if    = if_req && !if_ready_r;
  assign stall_exe   = exe_req && !exe_ready_r;

endmodule
